// File: rtl/me_stage.sv
// ----------------------------------------------------------------------------
// me_stage
// Memory-access pipeline stage between EX and WB. Holds one EX bundle, runs
// at most one scalar load/store on the data-memory bus and presents the
// writeback bundle to WB. Matrix results pass straight through.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module me_stage #(
  parameter int ADDR_W = 32,
  parameter int MAT_W  = 512
) (
  input  logic              clk,
  input  logic              rst,
  // EX side
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        ex_mem_op,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_store_data,
  input  logic [1:0]        ex_rd_group,
  input  logic [4:0]        ex_rd_index,
  input  logic [31:0]       ex_din_F,
  input  logic [MAT_W-1:0]  ex_din_M,
  // data-memory bus
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rdata,
  // WB side
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [1:0]        wb_rd_group,
  output logic [4:0]        wb_rd_index,
  output logic [31:0]       wb_din_R,
  output logic [31:0]       wb_din_F,
  output logic [MAT_W-1:0]  wb_din_M,
  output logic              misalign
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd8;
  localparam logic [3:0] OP_SH   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;

  localparam logic [1:0] GRP_F    = 2'd1;
  localparam logic [1:0] GRP_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    logic half_op;
    logic word_op;
    half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word_op = (op == OP_LW) || (op == OP_SW);
    return (half_op && a[0]) || (word_op && (a != 2'b00));
  endfunction

  state_t             state_q, state_d;
  logic               alive_q;
  logic [3:0]         op_q, op_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        sdata_q, sdata_d;
  logic [1:0]         grp_q, grp_d;
  logic [4:0]         idx_q, idx_d;
  logic [31:0]        r_q, r_d;
  logic [31:0]        f_q, f_d;
  logic [MAT_W-1:0]   m_q, m_d;
  logic               misalign_q, misalign_d;

  logic               accept;
  logic [31:0]        ld_shift;
  logic [31:0]        ld_val;

  // ex_ready stays low until the first clock after reset release
  assign ex_ready = alive_q && ((state_q == IDLE) || ((state_q == DONE) && wb_ready));
  assign accept   = ex_valid && ex_ready;

  assign wb_valid    = (state_q == DONE);
  assign wb_rd_group = grp_q;
  assign wb_rd_index = idx_q;
  assign wb_din_R    = r_q;
  assign wb_din_F    = f_q;
  assign wb_din_M    = m_q;
  assign misalign    = misalign_q;

  // Load data extraction: shift the addressed byte/half down, then extend
  always_comb begin
    ld_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (op_q)
      OP_LB:   ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      OP_LH:   ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      OP_LBU:  ld_val = {24'd0, ld_shift[7:0]};
      OP_LHU:  ld_val = {16'd0, ld_shift[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  // Memory request outputs, driven only while a request is pending
  always_comb begin
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wen       = 1'b0;
    mem_wdata     = 32'd0;
    mem_wstrb     = 4'd0;
    if (state_q == REQ) begin
      mem_req_valid = 1'b1;
      mem_addr      = ADDR_W'({addr_q[31:2], 2'b00});
      if (is_store(op_q)) begin
        mem_wen = 1'b1;
        case (op_q)
          OP_SB: begin
            mem_wstrb = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{sdata_q[7:0]}};
          end
          OP_SH: begin
            mem_wstrb = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{sdata_q[15:0]}};
          end
          default: begin
            mem_wstrb = 4'hF;
            mem_wdata = sdata_q;
          end
        endcase
      end
    end
  end

  // Next-state: bus progress first, then a new bundle dispatch overrides
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    grp_d      = grp_q;
    idx_d      = idx_q;
    r_d        = r_q;
    f_d        = f_q;
    m_d        = m_q;
    misalign_d = 1'b0;

    case (state_q)
      REQ: begin
        if (mem_req_ready) begin
          state_d = is_store(op_q) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          r_d     = ld_val;
          f_d     = ld_val;
          state_d = DONE;
        end
      end
      DONE: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      op_d    = ex_mem_op;
      addr_d  = ex_addr;
      sdata_d = ex_store_data;
      idx_d   = ex_rd_index;
      m_d     = ex_din_M;
      grp_d   = ex_rd_group;
      r_d     = ex_addr;
      f_d     = (ex_rd_group == GRP_F) ? ex_din_F : ex_addr;
      if (is_misaligned(ex_mem_op, ex_addr[1:0])) begin
        // dropped access: no bus activity, no register write
        state_d    = DONE;
        grp_d      = GRP_NONE;
        misalign_d = 1'b1;
      end else if (is_load(ex_mem_op)) begin
        state_d = REQ;
      end else if (is_store(ex_mem_op)) begin
        state_d = REQ;
        grp_d   = GRP_NONE;
      end else begin
        state_d = DONE;
      end
    end
  end

  // State and bundle registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      alive_q    <= 1'b0;
      op_q       <= OP_NONE;
      addr_q     <= 32'd0;
      sdata_q    <= 32'd0;
      grp_q      <= 2'd0;
      idx_q      <= 5'd0;
      r_q        <= 32'd0;
      f_q        <= 32'd0;
      m_q        <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      alive_q    <= 1'b1;
      op_q       <= op_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      grp_q      <= grp_d;
      idx_q      <= idx_d;
      r_q        <= r_d;
      f_q        <= f_d;
      m_q        <= m_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_me_stage.sv
// ----------------------------------------------------------------------------
// tb_me_stage
// Self-checking bench for me_stage: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction model.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_me_stage;

  localparam int ADDR_W = 32;
  localparam int MAT_W  = 512;

  logic              clk;
  logic              rst;
  logic              ex_valid;
  logic              ex_ready;
  logic [3:0]        ex_mem_op;
  logic [31:0]       ex_addr;
  logic [31:0]       ex_store_data;
  logic [1:0]        ex_rd_group;
  logic [4:0]        ex_rd_index;
  logic [31:0]       ex_din_F;
  logic [MAT_W-1:0]  ex_din_M;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rdata;
  logic              wb_valid;
  logic              wb_ready;
  logic [1:0]        wb_rd_group;
  logic [4:0]        wb_rd_index;
  logic [31:0]       wb_din_R;
  logic [31:0]       wb_din_F;
  logic [MAT_W-1:0]  wb_din_M;
  logic              misalign;

  int checks   = 0;
  int failures = 0;

  me_stage #(.ADDR_W(ADDR_W), .MAT_W(MAT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
    .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd_group(ex_rd_group),
    .ex_rd_index(ex_rd_index), .ex_din_F(ex_din_F), .ex_din_M(ex_din_M),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_group(wb_rd_group),
    .wb_rd_index(wb_rd_index), .wb_din_R(wb_din_R), .wb_din_F(wb_din_F),
    .wb_din_M(wb_din_M), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (arithmetic on the op semantics) -------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd8: return 1;
      4'd2, 4'd5, 4'd9: return 2;
      4'd3, 4'd10:      return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit m_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit m_store(input logic [3:0] op);
    return (op >= 4'd8) && (op <= 4'd10);
  endfunction

  function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
    int sz;
    sz = op_size(op);
    return (sz > 1) && ((a % sz) != 0);
  endfunction

  function automatic logic [31:0] m_load_val(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz;
    logic [31:0] v;
    logic [31:0] span;
    sz = op_size(op);
    v  = rd >> (8 * (a % 4));
    if (sz < 4) begin
      span = 32'd1 << (8 * sz);
      v = v % span;
      if (((op == 4'd1) || (op == 4'd2)) && (v >= (span / 2))) v = v - span;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [3:0] op, input logic [31:0] a);
    int sz;
    logic [7:0] s;
    sz = op_size(op);
    s  = ((8'd1 << sz) - 8'd1) << (a % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    int sz;
    logic [31:0] w;
    sz = op_size(op);
    w  = 32'd0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % sz) +: 8];
    return w;
  endfunction

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, sdata, rdata, dinF;
    logic [1:0]  grp;
    logic        exp_req, exp_wen;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_grp;
    logic        chk_data;
    logic [31:0] exp_R, exp_F;
    logic        exp_mis;
  } vec_t;

  function automatic vec_t mkv(
      input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
      input logic [31:0] rdata, input logic [31:0] dinF, input logic [1:0] grp,
      input logic exp_req, input logic exp_wen, input logic [31:0] exp_maddr,
      input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata, input logic [1:0] exp_grp,
      input logic chk_data, input logic [31:0] exp_R, input logic [31:0] exp_F,
      input logic exp_mis);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.dinF = dinF; v.grp = grp;
    v.exp_req = exp_req; v.exp_wen = exp_wen; v.exp_maddr = exp_maddr;
    v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata; v.exp_grp = exp_grp;
    v.chk_data = chk_data; v.exp_R = exp_R; v.exp_F = exp_F; v.exp_mis = exp_mis;
    return v;
  endfunction

  vec_t vecs[12];

  task automatic drive_idle();
    ex_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; wb_ready = 1'b0;
  endtask

  task automatic rand_mat(output logic [MAT_W-1:0] m);
    for (int k = 0; k < MAT_W / 32; k++) m[32*k +: 32] = $urandom;
  endtask

  // One directed transaction: request ready after 2 cycles, response one
  // cycle after the request handshake, WB ready one cycle after wb_valid.
  task automatic run_vec(input int i, input vec_t v);
    logic [MAT_W-1:0] m;
    int  req_cnt, mis_cnt;
    bit  req_done, req_seen, rsp_pend, wb_seen, done;
    logic [1:0]  g_grp;
    logic [4:0]  g_idx;
    logic [31:0] g_R, g_F;
    bit          g_M;
    rand_mat(m);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_op = v.op; ex_addr = v.addr; ex_store_data = v.sdata;
    ex_rd_group = v.grp; ex_rd_index = 5'(i); ex_din_F = v.dinF; ex_din_M = m;
    @(negedge clk);
    chk($sformatf("v%0d_accept", i), {31'd0, ex_ready}, 32'd1);
    req_cnt = 0; mis_cnt = 0; req_done = 0; req_seen = 0; rsp_pend = 0; wb_seen = 0; done = 0;
    g_grp = 0; g_idx = 0; g_R = 0; g_F = 0; g_M = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      ex_valid      = 1'b0;
      mem_req_ready = !req_done && (req_cnt >= 2);
      mem_rsp_valid = rsp_pend;
      mem_rdata     = rsp_pend ? v.rdata : $urandom;
      wb_ready      = wb_seen;
      @(negedge clk);
      if (misalign) mis_cnt++;
      if (mem_req_valid) begin
        req_seen = 1;
        req_cnt++;
        chk($sformatf("v%0d_maddr", i), mem_addr, v.exp_maddr);
        chk($sformatf("v%0d_wen", i), {31'd0, mem_wen}, {31'd0, v.exp_wen});
        chk($sformatf("v%0d_wstrb", i), {28'd0, mem_wstrb}, {28'd0, v.exp_wstrb});
        if (v.exp_wen) chk($sformatf("v%0d_wdata", i), mem_wdata, v.exp_wdata);
        if (mem_req_ready) begin
          req_done = 1;
          rsp_pend = !v.exp_wen;
        end
      end
      if (mem_rsp_valid) rsp_pend = 0;
      if (wb_valid) begin
        if (wb_ready) begin
          done = 1;
          g_grp = wb_rd_group; g_idx = wb_rd_index; g_R = wb_din_R; g_F = wb_din_F;
          g_M = (wb_din_M === m);
        end else begin
          wb_seen = 1;
        end
      end
    end
    @(posedge clk); #1;
    drive_idle();
    chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d_req_seen", i), {31'd0, req_seen}, {31'd0, v.exp_req});
    chk($sformatf("v%0d_misalign", i), mis_cnt, v.exp_mis ? 32'd1 : 32'd0);
    chk($sformatf("v%0d_grp", i), {30'd0, g_grp}, {30'd0, v.exp_grp});
    chk($sformatf("v%0d_idx", i), {27'd0, g_idx}, i);
    chk($sformatf("v%0d_M", i), {31'd0, g_M}, 32'd1);
    if (v.chk_data) begin
      chk($sformatf("v%0d_R", i), g_R, v.exp_R);
      chk($sformatf("v%0d_F", i), g_F, v.exp_F);
    end
  endtask

  // ---------------- randomized run against transaction model --------------
  typedef struct {
    logic [3:0]       op;
    logic [31:0]      addr, sdata, dinF, rdata;
    logic [1:0]       grp;
    logic [4:0]       idx;
    logic [MAT_W-1:0] dinM;
  } txn_t;

  txn_t q[$];

  task automatic gen_txn(output txn_t t);
    logic [3:0] ops[9];
    logic [MAT_W-1:0] m;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
    t.op    = ops[$urandom_range(0, 8)];
    t.addr  = $urandom;
    t.sdata = $urandom;
    t.dinF  = $urandom;
    t.rdata = $urandom;
    t.grp   = 2'($urandom_range(0, 3));
    t.idx   = 5'($urandom_range(0, 31));
    rand_mat(m);
    t.dinM  = m;
  endtask

  task automatic run_random(input int ncyc);
    txn_t cur, t;
    bit   have, rsp_pend, stop;
    int   rsp_dly, mis_cnt, stall;
    logic [31:0] v;
    have = 0; rsp_pend = 0; rsp_dly = 0; mis_cnt = 0; stall = 0; stop = 0;
    for (int cyc = 0; cyc < ncyc && !stop; cyc++) begin
      @(posedge clk); #1;
      if (!have && ($urandom_range(0, 9) < 7)) begin
        gen_txn(cur);
        have = 1;
      end
      ex_valid = have;
      ex_mem_op = cur.op; ex_addr = cur.addr; ex_store_data = cur.sdata;
      ex_rd_group = cur.grp; ex_rd_index = cur.idx; ex_din_F = cur.dinF; ex_din_M = cur.dinM;
      wb_ready      = ($urandom_range(0, 9) < 6);
      mem_req_ready = ($urandom_range(0, 1) == 1);
      if (rsp_pend && (rsp_dly == 0) && (q.size() > 0)) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = q[0].rdata;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rdata     = $urandom;
        if (rsp_pend) rsp_dly--;
      end
      @(negedge clk);
      if (misalign) mis_cnt++;
      if (mem_req_valid) begin
        if ((q.size() == 0) || !(m_load(q[0].op) || m_store(q[0].op)) || m_mis(q[0].op, q[0].addr)) begin
          chk("rnd_unexpected_req", 32'd1, 32'd0);
        end else begin
          t = q[0];
          chk("rnd_maddr", mem_addr, {t.addr[31:2], 2'b00});
          chk("rnd_wen", {31'd0, mem_wen}, m_store(t.op) ? 32'd1 : 32'd0);
          chk("rnd_wstrb", {28'd0, mem_wstrb}, m_store(t.op) ? {28'd0, m_wstrb(t.op, t.addr)} : 32'd0);
          if (m_store(t.op)) chk("rnd_wdata", mem_wdata, m_wdata(t.op, t.sdata));
          chk("rnd_ready_in_req", {31'd0, ex_ready}, 32'd0);
          if (mem_req_ready && m_load(t.op)) begin
            rsp_pend = 1;
            rsp_dly  = $urandom_range(0, 2);
          end
        end
      end
      if (mem_rsp_valid) rsp_pend = 0;
      if (wb_valid && wb_ready) begin
        stall = 0;
        if (q.size() == 0) begin
          chk("rnd_unexpected_wb", 32'd1, 32'd0);
        end else begin
          t = q.pop_front();
          if (m_store(t.op) || m_mis(t.op, t.addr)) begin
            chk("rnd_grp", {30'd0, wb_rd_group}, 32'd3);
          end else begin
            chk("rnd_grp", {30'd0, wb_rd_group}, {30'd0, t.grp});
            if (m_load(t.op)) begin
              v = m_load_val(t.op, t.addr, t.rdata);
              chk("rnd_load_R", wb_din_R, v);
              chk("rnd_load_F", wb_din_F, v);
            end else begin
              chk("rnd_alu_R", wb_din_R, t.addr);
              chk("rnd_alu_F", wb_din_F, (t.grp == 2'd1) ? t.dinF : t.addr);
            end
          end
          chk("rnd_idx", {27'd0, wb_rd_index}, {27'd0, t.idx});
          chk("rnd_M", {31'd0, wb_din_M === t.dinM}, 32'd1);
          chk("rnd_misalign", mis_cnt, m_mis(t.op, t.addr) ? 32'd1 : 32'd0);
          mis_cnt = 0;
        end
      end else if (q.size() > 0) begin
        stall++;
      end
      if (ex_valid && ex_ready) begin
        q.push_back(cur);
        have = 0;
      end
      if (stall > 100) begin
        chk("rnd_progress_timeout", 32'd1, 32'd0);
        stop = 1;
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    logic [MAT_W-1:0] m;
    rst = 1'b0;
    drive_idle();
    ex_mem_op = 0; ex_addr = 0; ex_store_data = 0; ex_rd_group = 0; ex_rd_index = 0;
    ex_din_F = 0; ex_din_M = '0; mem_rdata = 0;

    // Reset held with random inputs: everything quiet
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      ex_valid = 1'($urandom); ex_mem_op = 4'($urandom); ex_addr = $urandom;
      wb_ready = 1'($urandom); mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clk);
      chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      chk("rst_wb_R", wb_din_R, 32'd0);
    end
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel_ex_ready", {31'd0, ex_ready}, 32'd1);

    // Back-to-back ALU ops with WB always ready
    wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        ex_valid = 1'b1; ex_mem_op = 4'd0; ex_addr = i + 1; ex_rd_group = 2'd0;
        ex_rd_index = 5'd3;
      end else begin
        ex_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 4) chk($sformatf("b2b_ready%0d", i), {31'd0, ex_ready}, 32'd1);
      if (i >= 1) begin
        chk($sformatf("b2b_wbv%0d", i), {31'd0, wb_valid}, 32'd1);
        chk($sformatf("b2b_R%0d", i), wb_din_R, i);
      end
    end
    @(posedge clk); #1;
    drive_idle();

    // Directed vector table
    vecs[0]  = mkv(4'd1, 32'h1003, 0, 32'h80FF_FF00, 0, 2'd0, 1, 0, 32'h1000, 4'h0, 0, 2'd0, 1, 32'hFFFF_FF80, 32'hFFFF_FF80, 0);
    vecs[1]  = mkv(4'd5, 32'h2002, 0, 32'hBEEF_1234, 0, 2'd0, 1, 0, 32'h2000, 4'h0, 0, 2'd0, 1, 32'h0000_BEEF, 32'h0000_BEEF, 0);
    vecs[2]  = mkv(4'd8, 32'h3001, 32'h0000_00AB, 0, 0, 2'd0, 1, 1, 32'h3000, 4'b0010, 32'hABAB_ABAB, 2'd3, 0, 0, 0, 0);
    vecs[3]  = mkv(4'd3, 32'h4002, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 0, 0, 0, 1);
    vecs[4]  = mkv(4'd3, 32'h5004, 0, 32'hDEAD_BEEF, 32'h1111_1111, 2'd1, 1, 0, 32'h5004, 4'h0, 0, 2'd1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    vecs[5]  = mkv(4'd9, 32'h6002, 32'h1234_CDEF, 0, 0, 2'd1, 1, 1, 32'h6000, 4'b1100, 32'hCDEF_CDEF, 2'd3, 0, 0, 0, 0);
    vecs[6]  = mkv(4'd2, 32'h7000, 0, 32'h0000_8001, 0, 2'd0, 1, 0, 32'h7000, 4'h0, 0, 2'd0, 1, 32'hFFFF_8001, 32'hFFFF_8001, 0);
    vecs[7]  = mkv(4'd0, 32'h0000_0055, 0, 0, 32'h77, 2'd1, 0, 0, 0, 0, 0, 2'd1, 1, 32'h55, 32'h77, 0);
    vecs[8]  = mkv(4'd10, 32'h8000, 32'h1122_3344, 0, 0, 2'd0, 1, 1, 32'h8000, 4'hF, 32'h1122_3344, 2'd3, 0, 0, 0, 0);
    vecs[9]  = mkv(4'd4, 32'h9002, 0, 32'h00AB_0000, 0, 2'd2, 1, 0, 32'h9000, 4'h0, 0, 2'd2, 1, 32'h0000_00AB, 32'h0000_00AB, 0);
    vecs[10] = mkv(4'd9, 32'hA001, 32'h5555_5555, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 0, 0, 0, 1);
    vecs[11] = mkv(4'd1, 32'h0B01, 0, 32'h0000_7F00, 0, 2'd0, 1, 0, 32'h0B00, 4'h0, 0, 2'd0, 1, 32'h0000_007F, 32'h0000_007F, 0);
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // WB backpressure after an FLW, with a new bundle waiting on EX
    rand_mat(m);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_op = 4'd3; ex_addr = 32'h5000; ex_rd_group = 2'd1;
    ex_rd_index = 5'd7; ex_din_M = m;
    @(negedge clk);
    chk("bp_accept", {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    ex_mem_op = 4'd0; ex_addr = 32'h99; ex_rd_group = 2'd0; ex_rd_index = 5'd9;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("bp_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("bp_ready_req", {31'd0, ex_ready}, 32'd0);
    @(posedge clk); #1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("bp_ready_wait", {31'd0, ex_ready}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
      chk($sformatf("bp_wbv%0d", c), {31'd0, wb_valid}, 32'd1);
      chk($sformatf("bp_F%0d", c), wb_din_F, 32'hCAFE_F00D);
      chk($sformatf("bp_grp%0d", c), {30'd0, wb_rd_group}, 32'd1);
      chk($sformatf("bp_idx%0d", c), {27'd0, wb_rd_index}, 32'd7);
      chk($sformatf("bp_exr%0d", c), {31'd0, ex_ready}, 32'd0);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, ex_ready}, 32'd1);
    chk("bp_release_F", wb_din_F, 32'hCAFE_F00D);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_wbv", {31'd0, wb_valid}, 32'd1);
    chk("bp_next_R", wb_din_R, 32'h99);
    @(posedge clk); #1;
    drive_idle();

    // Reset in the middle of a load; a late response must be ignored
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_op = 4'd3; ex_addr = 32'h100; ex_rd_group = 2'd0;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("mid_rst_req", {31'd0, mem_req_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("late_rsp_ready", {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_wbv", {31'd0, wb_valid}, 32'd0);
    chk("late_rsp_req", {31'd0, mem_req_valid}, 32'd0);

    // Randomized traffic against the transaction model
    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/me_stage.md
Name: me_stage

Overview:
- Memory-access (ME) pipeline stage between EX and WB.
- Captures one EX result per valid/ready handshake and performs at most one scalar load or store on the data-memory request/response bus.
- Presents the writeback bundle (rd_group, rd_index, R/F/M data) to WB, which consumes it on its ready.
- Single-entry buffer. Matrix results pass through unchanged; this stage does no matrix memory ops.

Parameters:
ADDR_W, 32, data-memory address width
MAT_W, 512, flattened 4x4x32 matrix bus width (row-major, element [i][j] at bits 32*(4i+j) +: 32)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
ex_valid  in  1  EX bundle valid
ex_ready  out  1  ME can accept a bundle
ex_mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW
ex_addr  in  32  ALU result: memory address, or result for non-memory ops
ex_store_data  in  32  store source (from R or F, selected in EX)
ex_rd_group  in  2  `REG_GROUP_R/F/M; any other value = no write
ex_rd_index  in  5  destination index
ex_din_F  in  32  F result for non-load F ops
ex_din_M  in  MAT_W  matrix result
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
mem_wen  out  1  1 = store
mem_wdata  out  32  lane-shifted store data
mem_wstrb  out  4  byte strobes (0 for loads)
mem_rsp_valid  in  1  load data valid (never for stores)
mem_rdata  in  32  aligned load word
wb_valid  out  1  writeback bundle valid
wb_ready  in  1  WB consumes
wb_rd_group  out  2  destination group
wb_rd_index  out  5  destination index
wb_din_R  out  32  R writeback data
wb_din_F  out  32  F writeback data
wb_din_M  out  MAT_W  M writeback data
misalign  out  1  one-cycle pulse: misaligned access dropped

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, including ex_ready, mem_req_valid, wb_valid, misalign and every data bus. Reset mid-transaction abandons it; a later mem_rsp_valid is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - ex_ready=1.
  - On ex_valid, latch the whole bundle.
  - mem_op NONE -> DONE; wb_din_R = wb_din_F = ex_addr unless the group is F (then wb_din_F = ex_din_F). wb_valid rises the next cycle (latency 1).
  - Load/store, aligned -> REQ.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> DONE. wb_rd_group forced to 2'b11 (no write), misalign pulses 1 cycle, no bus activity.
- REQ:
  - mem_req_valid=1; mem_addr, mem_wen, mem_wdata, mem_wstrb held stable until mem_req_ready.
  - On mem_req_ready: store -> DONE; load -> WAIT.
  - Store lanes: SB wstrb = 1<<addr[1:0], wdata = byte replicated 4x. SH wstrb = 4'b0011 << addr[1:0], wdata = half replicated 2x. SW wstrb = 4'hF.
  - Stores force wb_rd_group = 2'b11.
- WAIT:
  - On mem_rsp_valid, extract the byte/half from mem_rdata >> (8*addr[1:0]). LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word.
  - Put the result on wb_din_R and wb_din_F; the group decides which is written (LW with group F = FLW). -> DONE.
- DONE:
  - wb_valid=1; outputs stable until wb_ready.
  - On wb_ready with ex_valid in the same cycle, the new bundle is accepted (ex_ready = wb_ready in DONE) and dispatched as from IDLE, giving zero bubbles for non-memory streams.
  - On wb_ready without ex_valid -> IDLE.
- ex_ready=0 in REQ and WAIT.
- Throughput:
  - Non-memory ops: 1 per cycle when wb_ready is held 1.
  - Loads: minimum 3 cycles (REQ, WAIT, DONE).
  - Stores: minimum 2 cycles.
- Writes with rd_group R and rd_index 0 pass through unchanged; WB discards them.

Test Plan:
- Reset: hold rst=0 with random inputs -> ex_ready=0, wb_valid=0, mem_req_valid=0. Release -> ex_ready=1 next cycle.
- Back-to-back ALU: 4 NONE ops, group R, ex_addr=1,2,3,4, wb_ready=1 -> wb_din_R = 1,2,3,4 on consecutive cycles, first one cycle after acceptance.
- LB sign-extend: addr=0x1003, mem_rdata=0x80FF_FF00, mem_req_ready delayed 2 cycles -> mem_addr=0x1000, wstrb=0, wb_din_R=0xFFFF_FF80.
- LHU: addr=0x2002, rdata=0xBEEF_1234 -> wb_din_R=0x0000_BEEF.
- SB: addr=0x3001, data=0x0000_00AB -> wstrb=4'b0010, wdata=0xABAB_ABAB, wb_rd_group=2'b11.
- Misaligned LW at addr=0x4002 -> misalign pulse, no mem_req_valid, wb_valid with group 2'b11.
- WB backpressure: wb_ready=0 for 5 cycles after an FLW -> wb bundle stable and ex_ready=0 throughout; accepted on the cycle wb_ready=1.
